// File: rtl/scoring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scoring_pkg                                                      |
// | Purpose : Shared types and defaults for the scoring matrix.                |
// |           score_t - one opaque 2-bit cell value (0..3)                     |
// |           col_t   - one column of DEFAULT_N cells                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package scoring_pkg;

  typedef logic [1:0] score_t;

  localparam int DEFAULT_N = 10;

  typedef score_t [DEFAULT_N-1:0] col_t;

endpackage
`default_nettype wire

// File: rtl/scoring_matrix_col.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scoring_matrix_col                                               |
// | Purpose : One matrix column of N score registers.                          |
// | Ports   : clk     - rising-edge clock                                      |
// |           rst     - synchronous active-high clear (wins over wr_en)        |
// |           wr_en   - load data_in into the column                           |
// |           data_in - column payload, data_in[r] is row r                    |
// |           col_q   - registered column contents                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module scoring_matrix_col
  import scoring_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  score_t [N-1:0]   data_in,
  output score_t [N-1:0]   col_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else if (wr_en) begin
      col_q <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scoring_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scoring_matrix                                                   |
// | Purpose : NxN matrix of 2-bit scores loaded one column per write cycle;   |
// |           done flags that every column was written since the last round. |
// | Ports   : clk        - rising-edge clock                                   |
// |           rst        - synchronous active-high reset                       |
// |           data_in    - column payload, data_in[r] is row r                 |
// |           data_valid - column write strobe, bit c writes column c         |
// |           done       - registered round-complete flag                      |
// |           matrix_out - registered matrix, indexed [row][col]               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module scoring_matrix
  import scoring_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0][1:0]         data_in,
  input  logic [N-1:0]              data_valid,
  output logic                      done,
  output logic [N-1:0][N-1:0][1:0]  matrix_out
);

  // Column storage; unpacked so each column instance drives its own element.
  score_t [N-1:0] col_q [N];

  logic [N-1:0] written_mask;
  logic [N-1:0] next_mask;
  logic         new_round;

  genvar c;
  generate
    for (c = 0; c < N; c++) begin : g_col
      scoring_matrix_col #(
        .N (N)
      ) u_col (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_valid[c]),
        .data_in (data_in),
        .col_q   (col_q[c])
      );
    end
  endgenerate

  // Pure rewiring from column-major storage to [row][col] output order.
  always_comb begin
    matrix_out = '0;
    for (int col = 0; col < N; col++) begin
      for (int row = 0; row < N; row++) begin
        matrix_out[row][col] = col_q[col][row];
      end
    end
  end

  // The first write after completion starts a fresh mask from that strobe
  // alone, so columns written in the previous round do not count again.
  always_comb begin
    new_round = done && (data_valid != '0);
    next_mask = new_round ? data_valid : (written_mask | data_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written_mask <= '0;
      done         <= 1'b0;
    end else begin
      written_mask <= next_mask;
      if (&next_mask) begin
        done <= 1'b1;
      end else if (new_round) begin
        done <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scoring_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_scoring_matrix                                                |
// | Purpose : Directed self-checking bench for scoring_matrix (N = 10).       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_scoring_matrix;

  localparam int N = 10;

  logic                     clk;
  logic                     rst;
  logic [N-1:0][1:0]        data_in;
  logic [N-1:0]             data_valid;
  logic                     done;
  logic [N-1:0][N-1:0][1:0] matrix_out;

  // Expected matrix, [row][col].
  logic [N-1:0][N-1:0][1:0] exp_m;

  int total;
  int bad;

  scoring_matrix #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .done       (done),
    .matrix_out (matrix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column payload (base + r) & 3 for every row.
  function automatic logic [N-1:0][1:0] pat(input int base);
    logic [N-1:0][1:0] d;
    for (int r = 0; r < N; r++) d[r] = 2'((base + r) & 3);
    return d;
  endfunction

  // Drive one strobe cycle and record the intended effect on the matrix.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0][1:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    #1;
    data_valid = '0;
    for (int c = 0; c < N; c++)
      if (v[c])
        for (int r = 0; r < N; r++) exp_m[r][c] = d[r];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    exp_m = '0;
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL reset_matrix: got %h want %h", matrix_out, exp_m);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_first_col;
    drive(10'h001, pat(0));
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL first_col_matrix: got %h want %h", matrix_out, exp_m);
    end
    total++;
    if (matrix_out[3][0] !== 2'd3 || matrix_out[5][0] !== 2'd1) begin
      bad++;
      $display("FAIL first_col_cells: got r3=%0d r5=%0d want 3 1",
               matrix_out[3][0], matrix_out[5][0]);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL first_col_done: got %b want 0", done);
    end
  endtask

  task automatic test_fill;
    for (int c = 1; c < N; c++) begin
      drive(10'(1 << c), pat(10 * c));
      total++;
      if (done !== (c == N - 1)) begin
        bad++;
        $display("FAIL fill_done_c%0d: got %b want %b", c, done, (c == N - 1));
      end
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL fill_matrix: got %h want %h", matrix_out, exp_m);
    end
  endtask

  task automatic test_idle_hold;
    idle(2);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL idle_done: got %b want 1", done);
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL idle_matrix: got %h want %h", matrix_out, exp_m);
    end
  endtask

  task automatic test_second_round;
    drive(10'h001, pat(123));
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL round2_first_done: got %b want 0", done);
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL round2_first_matrix: got %h want %h", matrix_out, exp_m);
    end
    for (int c = 1; c < N; c++) begin
      drive(10'(1 << c), pat(200 + c));
      total++;
      if (done !== (c == N - 1)) begin
        bad++;
        $display("FAIL round2_done_c%0d: got %b want %b", c, done, (c == N - 1));
      end
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL round2_matrix: got %h want %h", matrix_out, exp_m);
    end
  endtask

  // Col3 twice, then remaining columns in descending order.
  task automatic test_rewrite;
    drive(10'h008, pat(1));
    drive(10'h008, pat(2));
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rewrite_done_after_dup: got %b want 0", done);
    end
    for (int c = N - 1; c >= 0; c--) begin
      if (c != 3) begin
        drive(10'(1 << c), pat(c + 7));
        total++;
        if (done !== (c == 0)) begin
          bad++;
          $display("FAIL rewrite_done_c%0d: got %b want %b", c, done, (c == 0));
        end
      end
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL rewrite_matrix: got %h want %h", matrix_out, exp_m);
    end
  endtask

  task automatic test_all_ones;
    logic [N-1:0][1:0] d;
    d = '0;
    for (int r = 0; r < N; r++) d[r] = 2'd2;
    drive(10'h3FF, d);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL all_ones_done: got %b want 1", done);
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL all_ones_matrix: got %h want %h", matrix_out, exp_m);
    end
    drive(10'h020, pat(3));
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL after_all_ones_done: got %b want 0", done);
    end
  endtask

  task automatic test_reset_with_write;
    @(negedge clk);
    rst        = 1'b1;
    data_valid = 10'h3FF;
    data_in    = pat(1);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    data_valid = '0;
    exp_m      = '0;
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL rst_write_matrix: got %h want %h", matrix_out, exp_m);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rst_write_done: got %b want 0", done);
    end
    // Partial progress (col5) from before reset must be forgotten.
    for (int c = 0; c < N; c++) begin
      if (c != 5) drive(10'(1 << c), pat(c));
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mask_cleared: got %b want 0", done);
    end
    drive(10'h020, pat(9));
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL rst_refill_done: got %b want 1", done);
    end
    total++;
    if (matrix_out !== exp_m) begin
      bad++;
      $display("FAIL rst_refill_matrix: got %h want %h", matrix_out, exp_m);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    data_in    = '0;
    data_valid = '0;
    exp_m      = '0;
    test_reset();
    test_first_col();
    test_fill();
    test_idle_hold();
    test_second_round();
    test_rewrite();
    test_all_ones();
    test_reset_with_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
